if_id_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline latch of the 16-bit pipelined CPU; sits directly upstream of the ID stage.

---
 rtl/if_id_stage_pkg.sv | 23 ++
 rtl/if_id_stage_if.sv | 24 ++
 rtl/if_id_stage_fetch_ctrl.sv | 75 +++++++
 rtl/if_id_stage.sv | 69 ++++++
 tb/tb_if_id_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - word size, HLT/NOP encodings and the IF/ID entry type shared by the fetch slice
package if_id_stage_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

    localparam logic [3:0] OPCODE_HLT   = 4'hF;
    localparam logic [5:0] FUNC_HLT     = 6'd29;
    localparam word_t      NOP_ENCODING = 16'h0000;

    typedef struct packed {
        logic  valid;
        word_t inst;
        word_t pc;
        word_t pc_plus1;
    } if_id_entry_t;

    function automatic logic is_hlt(input word_t inst);
        return (inst[15:12] == OPCODE_HLT) && (inst[5:0] == FUNC_HLT);
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction memory request/ready handshake between fetch and memory
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic  i_readM;
    word_t i_address;
    word_t i_data;
    logic  i_inputReady;

    modport master (
        output i_readM,
        output i_address,
        input  i_data,
        input  i_inputReady
    );

    modport slave (
        input  i_readM,
        input  i_address,
        output i_data,
        output i_inputReady
    );

endinterface

// File: rtl/if_id_stage_fetch_ctrl.sv
// rtl/if_id_stage_fetch_ctrl.sv - fetch FSM and one-entry stall buffer; IF_HALT_DETECT_EN adds S_HALT
module if_id_stage_fetch_ctrl
    import if_id_stage_pkg::*;
#(
    parameter word_t NOP_INST = NOP_ENCODING
) (
    input  logic  Clk,
    input  logic  Reset_N,
    input  logic  stall,
    input  logic  flush,
    input  logic  input_ready,
    input  word_t data,
    output logic  read_req,
    output logic  deliver,
    output word_t deliver_inst
);

    localparam logic [2:0] S_REQ   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef IF_HALT_DETECT_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] after_deliver;
    word_t      buf_inst;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) state <= S_REQ;
        else          state <= state_next;
    end

    // Response captured while decode is stalled; only meaningful in S_HOLD.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)                                        buf_inst <= NOP_INST;
        else if (flush)                                      buf_inst <= NOP_INST;
        else if (state == S_WAIT && input_ready && stall)    buf_inst <= data;
    end

    always_comb begin
`ifdef IF_HALT_DETECT_EN
        after_deliver = is_hlt(deliver_inst) ? S_HALT : S_REQ;
`else
        after_deliver = S_REQ;
`endif
        state_next = state;
        if (flush) begin
            // Memory cannot cancel, so an outstanding read must still be absorbed.
            if ((state == S_WAIT || state == S_DRAIN) && !input_ready) state_next = S_DRAIN;
            else                                                       state_next = S_REQ;
        end else begin
            case (state)
                S_REQ:   state_next = S_WAIT;
                S_WAIT:  if (input_ready) state_next = stall ? S_HOLD : after_deliver;
                S_HOLD:  if (!stall)      state_next = after_deliver;
                S_DRAIN: if (input_ready) state_next = S_REQ;
`ifdef IF_HALT_DETECT_EN
                S_HALT:  state_next = S_HALT;
`endif
                default: state_next = S_REQ;
            endcase
        end
    end

    always_comb begin
        read_req     = (state == S_REQ) || (state == S_WAIT);
        deliver_inst = (state == S_HOLD) ? buf_inst : data;
        deliver      = !flush && !stall &&
                       ((state == S_WAIT && input_ready) || state == S_HOLD);
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC and IF/ID latch around the fetch controller; IF_HALT_DETECT_EN enables HLT stop
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000,
    parameter word_t NOP_INST = NOP_ENCODING
) (
    input  logic         Clk,
    input  logic         Reset_N,
    if_id_stage_if.master imem,
    input  logic         stall,
    input  logic         flush,
    input  word_t        flush_target,
    output logic         if_id_valid,
    output word_t        if_id_inst,
    output word_t        if_id_pc,
    output word_t        if_id_pc_plus1
);

    word_t pc;
    logic  read_req;
    logic  deliver;
    word_t deliver_inst;

    if_id_stage_fetch_ctrl #(.NOP_INST(NOP_INST)) u_fetch_ctrl (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .stall        (stall),
        .flush        (flush),
        .input_ready  (imem.i_inputReady),
        .data         (imem.i_data),
        .read_req     (read_req),
        .deliver      (deliver),
        .deliver_inst (deliver_inst)
    );

    // Reset forces the request low even though the FSM already sits in S_REQ.
    assign imem.i_readM   = read_req & Reset_N;
    assign imem.i_address = pc;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)     pc <= RESET_PC;
        else if (flush)   pc <= flush_target;
        else if (deliver) pc <= pc + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            if_id_valid    <= 1'b0;
            if_id_inst     <= NOP_INST;
            if_id_pc       <= 16'h0000;
            if_id_pc_plus1 <= 16'h0000;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end else if (!stall) begin
            if (deliver) begin
                if_id_valid    <= 1'b1;
                if_id_inst     <= deliver_inst;
                if_id_pc       <= pc;
                if_id_pc_plus1 <= pc + 16'd1;
            end else begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed bench with memory responder and per-cycle IF/ID reference model
module tb_if_id_stage;
    import if_id_stage_pkg::*;

    logic  Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic  Reset_N, rst2_n, stall, flush;
    word_t flush_target;
    logic  if_id_valid, v2;
    word_t if_id_inst, if_id_pc, if_id_pc_plus1, inst2, pc2, pc2_1;
    int    checks = 0;
    int    errors = 0;

    if_id_stage_if mi();
    if_id_stage_if mi2();

    if_id_stage #(.RESET_PC(16'h0000)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .imem(mi), .stall(stall), .flush(flush),
        .flush_target(flush_target), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1)
    );

    if_id_stage #(.RESET_PC(16'hFFFF)) dut2 (
        .Clk(Clk), .Reset_N(rst2_n), .imem(mi2), .stall(1'b0), .flush(1'b0),
        .flush_target(16'h0000), .if_id_valid(v2), .if_id_inst(inst2),
        .if_id_pc(pc2), .if_id_pc_plus1(pc2_1)
    );

    function automatic word_t memval(input word_t a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0001: return 16'h5678;
            16'h0002: return 16'hAAAA;
            16'h0003: return 16'h3333;
            16'h0008: return 16'h0808;
            16'h0010: return 16'h1010;
            16'h0011: return 16'hF01D;
            16'h0012: return 16'h1212;
            16'h0040: return 16'hC0DE;
            16'h0041: return 16'hBEEF;
            16'hFFFF: return 16'h7777;
            default:  return {4'h9, a[11:0]};
        endcase
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input bit second);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge Clk); #2;
            ok = second ? v2 : if_id_valid;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no valid instruction within 40 cycles expected one", name);
        end
    endtask

    task automatic wait_ready(input string name, input word_t addr);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge Clk); #2;
            ok = mi.i_inputReady && (mi.i_address == addr);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no response for %h within 40 cycles expected one", name, addr);
        end
    endtask

    // Memory for dut: accepts one read at a time, answers mem_lat cycles after the request edge.
    int    mem_lat = 1;
    int    mem_cnt = 0;
    logic  mem_busy = 1'b0;
    word_t mem_addr = 16'h0000;
    logic  rd_s = 1'b0;
    word_t ad_s = 16'h0000;
    logic  was_ready;

    always @(negedge Clk) begin
        rd_s = mi.i_readM;
        ad_s = mi.i_address;
    end

    always @(posedge Clk) begin
        #1;
        was_ready = mi.i_inputReady;
        mi.i_inputReady = 1'b0;
        if (!Reset_N) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mi.i_inputReady = 1'b1;
                mi.i_data = memval(mem_addr);
                mem_busy = 1'b0;
            end
        end else if (rd_s && !was_ready) begin
            mem_addr = ad_s;
            mem_cnt  = mem_lat - 1;
            if (mem_cnt <= 0) begin
                mi.i_inputReady = 1'b1;
                mi.i_data = memval(ad_s);
            end else begin
                mem_busy = 1'b1;
            end
        end
    end

    // Single-cycle-latency memory for dut2.
    logic  rd2_s = 1'b0;
    word_t ad2_s = 16'h0000;

    always @(negedge Clk) begin
        rd2_s = mi2.i_readM;
        ad2_s = mi2.i_address;
    end

    always @(posedge Clk) begin
        #1;
        if (mi2.i_inputReady) mi2.i_inputReady = 1'b0;
        else if (rst2_n && rd2_s) begin
            mi2.i_inputReady = 1'b1;
            mi2.i_data = memval(ad2_s);
        end
    end

    // Reference model: instructions retire in program order from exp_pc, flush redirects it.
    word_t exp_pc = 16'h0000;
    logic  p_stall = 1'b0, p_flush = 1'b0, pv = 1'b0;
    word_t p_target = 16'h0000, pi = 16'h0000, pp = 16'h0000, pp1 = 16'h0000;

    always @(negedge Clk) begin
        if (!Reset_N) begin
            exp_pc = 16'h0000;
        end else begin
            if (p_flush) begin
                chk("model_flush_valid", 16'(if_id_valid), 16'h0000);
                chk("model_flush_inst", if_id_inst, NOP_ENCODING);
            end else if (p_stall) begin
                chk("model_hold_valid", 16'(if_id_valid), 16'(pv));
                chk("model_hold_inst", if_id_inst, pi);
                chk("model_hold_pc", if_id_pc, pp);
                chk("model_hold_pc1", if_id_pc_plus1, pp1);
            end else if (if_id_valid) begin
                chk("model_pc", if_id_pc, exp_pc);
                chk("model_inst", if_id_inst, memval(exp_pc));
                chk("model_pc1", if_id_pc_plus1, exp_pc + 16'd1);
                exp_pc = exp_pc + 16'd1;
            end else begin
                chk("model_bubble_inst", if_id_inst, NOP_ENCODING);
            end
            if (p_flush) exp_pc = p_target;
            chk("model_fetch_addr", mi.i_address, exp_pc);
        end
        p_stall = stall; p_flush = flush; p_target = flush_target;
        pv = if_id_valid; pi = if_id_inst; pp = if_id_pc; pp1 = if_id_pc_plus1;
    end

    initial begin
        Reset_N = 1'b0; rst2_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = 16'h0000;
        mi.i_inputReady = 1'b0; mi.i_data = 16'h0000;
        mi2.i_inputReady = 1'b0; mi2.i_data = 16'h0000;
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_valid", 16'(if_id_valid), 16'h0000);
        chk("rst_inst", if_id_inst, 16'h0000);
        chk("rst_pc", if_id_pc, 16'h0000);
        chk("rst_pc1", if_id_pc_plus1, 16'h0000);
        chk("rst_readM", 16'(mi.i_readM), 16'h0000);
        chk("rst_addr", mi.i_address, 16'h0000);
        Reset_N = 1'b1;

        wait_valid("t1_first", 1'b0);
        chk("t1_inst0", if_id_inst, 16'h1234);
        chk("t1_pc0", if_id_pc, 16'h0000);
        chk("t1_pc1_0", if_id_pc_plus1, 16'h0001);
        wait_valid("t1_second", 1'b0);
        chk("t1_inst1", if_id_inst, 16'h5678);
        chk("t1_pc1", if_id_pc, 16'h0001);
        chk("t1_pc1_1", if_id_pc_plus1, 16'h0002);

        wait_ready("t2_ready", 16'h0002);
        stall = 1'b1;
        @(posedge Clk); #2;
        chk("t2_hold_readM", 16'(mi.i_readM), 16'h0000);
        chk("t2_hold_valid", 16'(if_id_valid), 16'h0000);
        repeat (2) @(posedge Clk);
        #2;
        chk("t2_hold_readM_late", 16'(mi.i_readM), 16'h0000);
        stall = 1'b0;
        @(posedge Clk); #2;
        chk("t2_release_valid", 16'(if_id_valid), 16'h0001);
        chk("t2_inst", if_id_inst, 16'hAAAA);
        chk("t2_pc", if_id_pc, 16'h0002);
        chk("t2_next_addr", mi.i_address, 16'h0003);

        mem_lat = 3;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(posedge Clk); #2;
                ok = mem_busy && (mi.i_address == 16'h0003);
            end
            chk("t3_wait_reached", 16'(ok), 16'h0001);
        end
        flush = 1'b1; flush_target = 16'h0040;
        @(posedge Clk); #2;
        flush = 1'b0;
        chk("t3_bubble", 16'(if_id_valid), 16'h0000);
        chk("t3_drain_readM", 16'(mi.i_readM), 16'h0000);
        chk("t3_addr", mi.i_address, 16'h0040);
        wait_valid("t3_land", 1'b0);
        chk("t3_inst", if_id_inst, 16'hC0DE);
        chk("t3_pc", if_id_pc, 16'h0040);
        mem_lat = 1;

        wait_ready("t4_ready", 16'h0041);
        stall = 1'b1; flush = 1'b1; flush_target = 16'h0010;
        @(posedge Clk); #2;
        stall = 1'b0; flush = 1'b0;
        chk("t4_valid", 16'(if_id_valid), 16'h0000);
        chk("t4_inst", if_id_inst, 16'h0000);
        chk("t4_addr", mi.i_address, 16'h0010);
        chk("t4_readM", 16'(mi.i_readM), 16'h0001);
        wait_valid("t4_land", 1'b0);
        chk("t4_land_inst", if_id_inst, 16'h1010);
        chk("t4_land_pc", if_id_pc, 16'h0010);

        wait_valid("t6_hlt", 1'b0);
        chk("t6_hlt_inst", if_id_inst, 16'hF01D);
        chk("t6_hlt_pc", if_id_pc, 16'h0011);
`ifdef IF_HALT_DETECT_EN
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #2;
            chk("t6_halt_readM", 16'(mi.i_readM), 16'h0000);
        end
        chk("t6_halt_valid", 16'(if_id_valid), 16'h0000);
        flush = 1'b1; flush_target = 16'h0008;
        @(posedge Clk); #2;
        flush = 1'b0;
        wait_valid("t6_resume", 1'b0);
        chk("t6_resume_inst", if_id_inst, 16'h0808);
        chk("t6_resume_pc", if_id_pc, 16'h0008);
`else
        wait_valid("t6_next", 1'b0);
        chk("t6_next_inst", if_id_inst, 16'h1212);
        chk("t6_next_pc", if_id_pc, 16'h0012);
`endif

        rst2_n = 1'b1;
        wait_valid("t5_first", 1'b1);
        chk("t5_inst", inst2, 16'h7777);
        chk("t5_pc", pc2, 16'hFFFF);
        chk("t5_pc1", pc2_1, 16'h0000);
        chk("t5_next_addr", mi2.i_address, 16'h0000);
        wait_valid("t5_second", 1'b1);
        chk("t5_inst2", inst2, 16'h1234);
        chk("t5_pc_wrap", pc2, 16'h0000);
        chk("t5_pc1_wrap", pc2_1, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
